// File: rtl/stopwatch_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | stopwatch_core: MM:SS BCD stopwatch with debounced pause/clear and adjust. |
// | Optional macro STOPWATCH_CORE_BLINK_EN enables adjust-field blink mask.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module stopwatch_core #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1hz,
  input  logic       tick_2hz,
  input  logic       btn_pause,
  input  logic       btn_clr,
  input  logic       sel,
  input  logic       adj,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       paused,
  output logic [3:0] blink_mask
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    PAUSE  = 2'd1,
    ADJUST = 2'd2
  } state_t;

  // Synchronizer bit order: 0 pause, 1 clear, 2 sel, 3 adj.
  logic [3:0] sync1_q;
  logic [3:0] sync2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {adj, sel, btn_clr, btn_pause};
      sync2_q <= sync1_q;
    end
  end

  logic [1:0] press_w;

  for (genvar gi = 0; gi < 2; gi++) begin : g_debounce
    logic             stable_q;
    logic [CNT_W-1:0] cnt_q;
    logic             differ_w;

    assign differ_w = (sync2_q[gi] != stable_q);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        stable_q <= 1'b0;
        cnt_q    <= '0;
      end else if (!differ_w) begin
        cnt_q <= '0;
      end else if (cnt_q == DB_LAST) begin
        stable_q <= sync2_q[gi];
        cnt_q    <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end

    // Pulse fires in the cycle whose edge accepts the new high level.
    assign press_w[gi] = differ_w && sync2_q[gi] && (cnt_q == DB_LAST);
  end

  function automatic logic [7:0] bcd_inc59(input logic [7:0] f);
    logic [7:0] r;
    if (f[3:0] == 4'd9) begin
      r[3:0] = 4'd0;
      r[7:4] = (f[7:4] >= 4'd5) ? 4'd0 : f[7:4] + 4'd1;
    end else begin
      r[3:0] = f[3:0] + 4'd1;
      r[7:4] = f[7:4];
    end
    return r;
  endfunction

  logic   pause_press_w;
  logic   clr_press_w;
  logic   adj_s_w;
  logic   sel_s_w;

  assign pause_press_w = press_w[0];
  assign clr_press_w   = press_w[1];
  assign sel_s_w       = sync2_q[2];
  assign adj_s_w       = sync2_q[3];

  state_t     state_q, state_d;
  logic [7:0] min_q, min_d;
  logic [7:0] sec_q, sec_d;
  logic       paused_q, paused_d;

  always_comb begin
    min_d    = min_q;
    sec_d    = sec_q;
    paused_d = paused_q;
    if (pause_press_w) paused_d = ~paused_q;

    if (clr_press_w) begin
      min_d    = 8'h00;
      sec_d    = 8'h00;
      paused_d = 1'b0;
    end else if (state_q == ADJUST) begin
      if (tick_2hz) begin
        if (sel_s_w) sec_d = bcd_inc59(sec_q);
        else         min_d = bcd_inc59(min_q);
      end
    end else if (state_q == RUN && tick_1hz) begin
      sec_d = bcd_inc59(sec_q);
      if (sec_q == 8'h59) min_d = bcd_inc59(min_q);
    end

    if (adj_s_w)       state_d = ADJUST;
    else if (paused_d) state_d = PAUSE;
    else               state_d = RUN;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RUN;
      min_q    <= 8'h00;
      sec_q    <= 8'h00;
      paused_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      min_q    <= min_d;
      sec_q    <= sec_d;
      paused_q <= paused_d;
    end
  end

  assign min_tens = min_q[7:4];
  assign min_ones = min_q[3:0];
  assign sec_tens = sec_q[7:4];
  assign sec_ones = sec_q[3:0];
  assign paused   = paused_q;

`ifdef STOPWATCH_CORE_BLINK_EN
  logic       blink_ph_q;
  logic       blink_ph_d;
  logic [3:0] blink_q;

  assign blink_ph_d = (state_q == ADJUST && tick_2hz) ? ~blink_ph_q : blink_ph_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_ph_q <= 1'b0;
      blink_q    <= 4'b0000;
    end else if (state_d != ADJUST) begin
      blink_ph_q <= 1'b0;
      blink_q    <= 4'b0000;
    end else begin
      blink_ph_q <= blink_ph_d;
      blink_q    <= sel_s_w ? {2'b00, {2{blink_ph_d}}} : {{2{blink_ph_d}}, 2'b00};
    end
  end

  assign blink_mask = blink_q;
`else
  assign blink_mask = 4'b0000;
`endif

endmodule
`default_nettype wire

// File: doc/stopwatch_core.md
STOPWATCH_CORE -- requirements
Module: stopwatch_core

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000, consecutive clk cycles a raw button must hold a new level before it is accepted (10 ms at 100 MHz).
REQ-002 clk  input  1  system clock, 100 MHz; all state is clocked on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 tick_1hz  input  1  one-clk-cycle enable pulse, once per second.
REQ-005 tick_2hz  input  1  one-clk-cycle enable pulse, twice per second.
REQ-006 btn_pause  input  1  raw, asynchronous pause pushbutton, active-high.
REQ-007 btn_clr  input  1  raw, asynchronous clear pushbutton, active-high.
REQ-008 sel  input  1  raw switch: 0 selects minutes, 1 selects seconds, for adjust.
REQ-009 adj  input  1  raw switch: 1 selects adjust mode.
REQ-010 min_tens, min_ones, sec_tens, sec_ones  output  4 each  registered BCD digits of MM:SS, sent to the display mux.
REQ-011 paused  output  1  registered; 1 while counting is frozen by the pause toggle.
REQ-012 blink_mask  output  4  registered; a bit set to 1 blanks that digit, bit3=min_tens through bit0=sec_ones.

Function
REQ-013 btn_pause, btn_clr, sel and adj SHALL each pass through a 2-flop synchronizer before any other use.
REQ-014 btn_pause and btn_clr SHALL each be debounced as follows: the stable level updates only after the synchronized level differs from it for DEBOUNCE_CYCLES consecutive cycles; any agreeing cycle restarts the count.
REQ-015 A 0->1 change of the debounced level SHALL produce a one-cycle internal press pulse; holding the button produces no further pulse.
REQ-016 State machine states: RUN, PAUSE, ADJUST; state register reset value is RUN.
REQ-017 RUN: on tick_1hz, MM:SS SHALL increment by one second in BCD; x9->x0 carries into the next digit; SS 59->00 carries into MM; 59:59->00:00 wraps with no other effect.
REQ-018 RUN->PAUSE and PAUSE->RUN SHALL occur on a pause press pulse; PAUSE ignores tick_1hz.
REQ-019 Any state SHALL go to ADJUST when synchronized adj=1; leaving ADJUST returns to PAUSE if paused=1, otherwise to RUN.
REQ-020 ADJUST: tick_1hz is ignored; on tick_2hz the selected field (per synchronized sel) SHALL increment by 1 and wrap 59->00 with no carry into the other field.
REQ-021 Pause press pulses SHALL toggle paused in every state, including ADJUST.
REQ-022 A clear press pulse SHALL set all digits to 0 and paused to 0 in any state; an ADJUST state is kept.
REQ-023 Priority within one cycle: clear > adjust increment > run tick; for a pause press and tick_1hz in the same cycle, the tick is evaluated against the pre-edge state.
REQ-024 Digit outputs SHALL change on the clk edge that samples the qualifying tick or press, which is 1 cycle of latency, and never take values outside 0-9 or tens>5.

Reset
REQ-025 While rst_n=0, all digits and paused SHALL read 0, blink_mask 4'b0000, state RUN, and synchronizers, debounce counters and stable levels all 0.
REQ-026 If rst_n asserts mid-debounce or mid-adjust, the block SHALL abort it with no pulse; after release, a button already held produces a press only after a full DEBOUNCE_CYCLES.

Configuration
REQ-027 Macro STOPWATCH_CORE_BLINK_EN: when defined, in ADJUST the two bits of the selected field in blink_mask SHALL toggle on each tick_2hz and clear to 0 on leaving ADJUST; the other two bits stay 0.
REQ-028 When STOPWATCH_CORE_BLINK_EN is not defined, blink_mask SHALL be constant 4'b0000 and no blink logic is synthesized.

Verification (DEBOUNCE_CYCLES=4 in the bench)
REQ-029 Reset, then 61 tick_1hz pulses -> digits 01:01, paused=0.
REQ-030 Preload 59:59 by adjusting, then RUN with 1 tick_1hz -> 00:00.
REQ-031 btn_pause high 3 cycles, then low -> no toggle; held 10 cycles -> paused=1 once; 5 ticks -> digits unchanged.
REQ-032 adj=1, sel=1, from 00:58, 3 tick_2hz -> 00:01 with minutes unchanged; tick_1hz ignored; with BLINK_EN, blink_mask alternates 4'b0011/4'b0000.
REQ-033 Clear press coinciding with tick_1hz at 12:34 -> 00:00 and paused=0 on the same edge.
REQ-034 rst_n pulsed low asynchronously mid-count, between clk edges -> outputs 0 immediately; held btn_pause yields a press only after 4 cycles following release.
